i2c_slave_ctrl: RTL and testbench

- Byte-level I2C slave sequencer for the temperature/humidity controller.
- Consumes the SCL rising/falling edge strobes from the SCL edge detector and a pre-synchronised SDA.
- Detects START/STOP, matches the 7-bit address, receives write bytes, serves read bytes and generates/samples ACK.
- Drives SDA open-drain through an output-enable; the register file sits behind the rx/tx byte interface.

---
 rtl/i2c_slave_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_ctrl.sv
// Byte-level I2C slave sequencer: START/STOP detection, 7-bit address match,
// write-byte reception, read-byte serving and ACK generation/sampling.
module i2c_slave_ctrl #(
   parameter logic [6:0] SLAVE_ADDR = 7'h40
) (
   input  logic       pclk,
   input  logic       presetn,
   input  logic       scl_in,
   input  logic       sda_in,
   input  logic       tx_edge,
   input  logic       rx_edge,
   input  logic [7:0] tx_data,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_load,
   output logic       rw,
   output logic       busy
);

   typedef enum logic [3:0] {
      IDLE, ADDR, ACK_ADDR, RX, ACK_RX, TX, MACK, TX_LOAD, WAIT_STOP
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] sr_q, sr_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       phase_q, phase_d;
   logic       sda_oe_q, sda_oe_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tx_load_q, tx_load_d;
   logic       rw_q, rw_d;
   logic       busy_q, busy_d;
   logic       sda_d_q;

   logic       start_det, stop_det, rx_ev, tx_ev;
   logic [7:0] sr_shift;

   assign start_det = scl_in & sda_d_q & ~sda_in;
   assign stop_det  = scl_in & ~sda_d_q & sda_in;
   assign rx_ev     = rx_edge;
   assign tx_ev     = tx_edge & ~rx_edge;
   assign sr_shift  = {sr_q[6:0], sda_in};

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q    <= IDLE;
         bit_cnt_q  <= 3'd0;
         sr_q       <= 8'h00;
         rx_data_q  <= 8'h00;
         phase_q    <= 1'b0;
         sda_oe_q   <= 1'b0;
         rx_valid_q <= 1'b0;
         tx_load_q  <= 1'b0;
         rw_q       <= 1'b0;
         busy_q     <= 1'b0;
         sda_d_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         sr_q       <= sr_d;
         rx_data_q  <= rx_data_d;
         phase_q    <= phase_d;
         sda_oe_q   <= sda_oe_d;
         rx_valid_q <= rx_valid_d;
         tx_load_q  <= tx_load_d;
         rw_q       <= rw_d;
         busy_q     <= busy_d;
         sda_d_q    <= sda_in;
      end
   end

   // phase_q separates the "drive ACK" edge from the "end of ACK slot" edge
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      sr_d       = sr_q;
      rx_data_d  = rx_data_q;
      phase_d    = phase_q;
      sda_oe_d   = sda_oe_q;
      rx_valid_d = 1'b0;
      tx_load_d  = 1'b0;
      rw_d       = rw_q;
      busy_d     = busy_q;

      if (start_det) begin
         sda_oe_d  = 1'b0;
         bit_cnt_d = 3'd0;
         busy_d    = 1'b0;
         phase_d   = 1'b0;
         state_d   = ADDR;
      end else if (stop_det) begin
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
         state_d  = IDLE;
      end else begin
         case (state_q)
            IDLE: ;
            ADDR: begin
               if (rx_ev) begin
                  sr_d      = sr_shift;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     phase_d = 1'b0;
                     if (sr_shift[7:1] == SLAVE_ADDR) begin
                        rw_d    = sr_shift[0];
                        state_d = ACK_ADDR;
                     end else begin
                        sda_oe_d = 1'b0;
                        state_d  = WAIT_STOP;
                     end
                  end
               end
            end
            ACK_ADDR: begin
               if (tx_ev) begin
                  if (!phase_q) begin
                     sda_oe_d = 1'b1;
                     busy_d   = 1'b1;
                     phase_d  = 1'b1;
                  end else begin
                     phase_d   = 1'b0;
                     bit_cnt_d = 3'd0;
                     if (rw_q) begin
                        sr_d      = tx_data;
                        tx_load_d = 1'b1;
                        sda_oe_d  = ~tx_data[7];
                        state_d   = TX;
                     end else begin
                        sda_oe_d = 1'b0;
                        state_d  = RX;
                     end
                  end
               end
            end
            RX: begin
               if (rx_ev) begin
                  sr_d      = sr_shift;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     rx_data_d  = sr_shift;
                     rx_valid_d = 1'b1;
                     phase_d    = 1'b0;
                     state_d    = ACK_RX;
                  end
               end
            end
            ACK_RX: begin
               if (tx_ev) begin
                  if (!phase_q) begin
                     sda_oe_d = 1'b1;
                     phase_d  = 1'b1;
                  end else begin
                     sda_oe_d = 1'b0;
                     phase_d  = 1'b0;
                     state_d  = RX;
                  end
               end
            end
            // bit_cnt counts shifts already made; at 7 bit 0 has been on the bus
            TX: begin
               if (tx_ev) begin
                  if (bit_cnt_q == 3'd7) begin
                     sda_oe_d = 1'b0;
                     state_d  = MACK;
                  end else begin
                     sr_d      = {sr_q[6:0], 1'b0};
                     sda_oe_d  = ~sr_q[6];
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end
            end
            MACK: begin
               if (rx_ev) begin
                  if (sda_in) begin
                     busy_d  = 1'b0;
                     state_d = WAIT_STOP;
                  end else begin
                     state_d = TX_LOAD;
                  end
               end
            end
            TX_LOAD: begin
               if (tx_ev) begin
                  sr_d      = tx_data;
                  tx_load_d = 1'b1;
                  sda_oe_d  = ~tx_data[7];
                  bit_cnt_d = 3'd0;
                  state_d   = TX;
               end
            end
            WAIT_STOP: sda_oe_d = 1'b0;
            default:   state_d = IDLE;
         endcase
      end
   end

   assign sda_oe   = sda_oe_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_load  = tx_load_q;
   assign rw       = rw_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed testbench for i2c_slave_ctrl: bit-banged I2C master with a
// wired-AND SDA bus and hand-computed expectations.
module tb_i2c_slave_ctrl;

   logic       pclk = 1'b0;
   logic       presetn;
   logic       scl;
   logic       sdaMaster;
   logic       txEdge;
   logic       rxEdge;
   logic [7:0] txData;
   logic       sdaOe;
   logic [7:0] rxData;
   logic       rxValid;
   logic       txLoad;
   logic       rw;
   logic       busy;
   logic       sdaBus;

   int errorCount = 0;
   int checkCount = 0;

   int         rxValidCount = 0;
   int         txLoadCount  = 0;
   int         oeHighCount  = 0;
   int         txIdx        = 0;
   logic [7:0] lastRx       = 8'h00;
   logic [7:0] txBytes [4]  = '{8'hA5, 8'h3C, 8'h4E, 8'h00};

   assign sdaBus = sdaMaster & ~sdaOe;
   assign txData = txBytes[txIdx];

   always #5 pclk = ~pclk;

   i2c_slave_ctrl #(.SLAVE_ADDR(7'h40)) dut (
      .pclk     (pclk),
      .presetn  (presetn),
      .scl_in   (scl),
      .sda_in   (sdaBus),
      .tx_edge  (txEdge),
      .rx_edge  (rxEdge),
      .tx_data  (txData),
      .sda_oe   (sdaOe),
      .rx_data  (rxData),
      .rx_valid (rxValid),
      .tx_load  (txLoad),
      .rw       (rw),
      .busy     (busy)
   );

   // Event monitors: pulses, last received byte, and the read-byte source
   always @(posedge pclk) begin
      if (rxValid) begin
         rxValidCount <= rxValidCount + 1;
         lastRx       <= rxData;
      end
      if (txLoad) begin
         txLoadCount <= txLoadCount + 1;
         if (txIdx < 3) txIdx <= txIdx + 1;
      end
      if (sdaOe) oeHighCount <= oeHighCount + 1;
   end

   task automatic checkOutput(input string tag, input logic [15:0] actual,
                              input logic [15:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic waitCyc(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic sclRise;
      @(negedge pclk);
      scl = 1'b1; rxEdge = 1'b1;
      @(negedge pclk);
      rxEdge = 1'b0;
   endtask

   task automatic sclFall;
      @(negedge pclk);
      scl = 1'b0; txEdge = 1'b1;
      @(negedge pclk);
      txEdge = 1'b0;
   endtask

   task automatic sendBit(input logic b);
      sdaMaster = b;
      waitCyc(2);
      sclRise;
      waitCyc(3);
      sclFall;
      waitCyc(2);
   endtask

   task automatic startCond;
      sdaMaster = 1'b1;
      waitCyc(2);
      if (scl == 1'b0) sclRise;
      waitCyc(2);
      sdaMaster = 1'b0;
      waitCyc(3);
      sclFall;
      waitCyc(2);
   endtask

   task automatic stopCond;
      sdaMaster = 1'b0;
      waitCyc(2);
      if (scl == 1'b0) sclRise;
      waitCyc(2);
      sdaMaster = 1'b1;
      waitCyc(3);
   endtask

   // Master writes a byte and checks the slave's ACK slot and SDA afterwards
   task automatic applyStimulus(input string tag, input logic [7:0] b,
                                input logic ackExp, input logic oeAfterExp);
      for (int i = 7; i >= 0; i--) sendBit(b[i]);
      sdaMaster = 1'b1;
      checkOutput({tag, ".ackOe"}, 16'(sdaOe), 16'(ackExp));
      waitCyc(2);
      sclRise;
      checkOutput({tag, ".ackBus"}, 16'(sdaBus), 16'(!ackExp));
      waitCyc(3);
      sclFall;
      waitCyc(2);
      checkOutput({tag, ".oeAfter"}, 16'(sdaOe), 16'(oeAfterExp));
   endtask

   task automatic readByte(input string tag, input logic masterAck,
                           input logic [7:0] expected);
      logic [7:0] data;
      data = 8'h00;
      sdaMaster = 1'b1;
      for (int i = 0; i < 8; i++) begin
         waitCyc(2);
         sclRise;
         data = {data[6:0], sdaBus};
         waitCyc(3);
         sclFall;
      end
      waitCyc(2);
      checkOutput({tag, ".data"}, 16'(data), 16'(expected));
      checkOutput({tag, ".release"}, 16'(sdaOe), 16'h0);
      sdaMaster = masterAck ? 1'b0 : 1'b1;
      waitCyc(2);
      sclRise;
      waitCyc(3);
      sclFall;
      sdaMaster = 1'b1;
      waitCyc(2);
   endtask

   initial begin
      int rv0, tl0, oe0;
      presetn = 1'b0; scl = 1'b1; sdaMaster = 1'b1; txEdge = 1'b0; rxEdge = 1'b0;
      waitCyc(3);
      checkOutput("rst.sdaOe", 16'(sdaOe), 16'h0);
      checkOutput("rst.rxData", 16'(rxData), 16'h0);
      checkOutput("rst.rxValid", 16'(rxValid), 16'h0);
      checkOutput("rst.txLoad", 16'(txLoad), 16'h0);
      checkOutput("rst.rw", 16'(rw), 16'h0);
      checkOutput("rst.busy", 16'(busy), 16'h0);
      presetn = 1'b1;
      waitCyc(2);

      // Write 0x5A to address 0x40
      rv0 = rxValidCount;
      startCond;
      applyStimulus("wr.addr", 8'h80, 1'b1, 1'b0);
      checkOutput("wr.busy", 16'(busy), 16'h1);
      checkOutput("wr.rw", 16'(rw), 16'h0);
      applyStimulus("wr.data", 8'h5A, 1'b1, 1'b0);
      checkOutput("wr.rxCount", 16'(rxValidCount - rv0), 16'h1);
      checkOutput("wr.lastRx", 16'(lastRx), 16'h5A);
      stopCond;
      checkOutput("wr.busyStop", 16'(busy), 16'h0);

      // Address mismatch: slave never touches SDA
      rv0 = rxValidCount; oe0 = oeHighCount;
      startCond;
      applyStimulus("mis.addr", 8'h82, 1'b0, 1'b0);
      applyStimulus("mis.data", 8'h11, 1'b0, 1'b0);
      checkOutput("mis.oeCount", 16'(oeHighCount - oe0), 16'h0);
      checkOutput("mis.rxCount", 16'(rxValidCount - rv0), 16'h0);
      checkOutput("mis.busy", 16'(busy), 16'h0);
      stopCond;

      // Read two bytes, ACK then NACK
      tl0 = txLoadCount;
      startCond;
      applyStimulus("rd.addr", 8'h81, 1'b1, 1'b0);
      checkOutput("rd.rw", 16'(rw), 16'h1);
      readByte("rd.b0", 1'b1, 8'hA5);
      readByte("rd.b1", 1'b0, 8'h3C);
      checkOutput("rd.txLoads", 16'(txLoadCount - tl0), 16'h2);
      checkOutput("rd.oeNack", 16'(sdaOe), 16'h0);
      checkOutput("rd.busyNack", 16'(busy), 16'h0);
      stopCond;

      // Repeated START: write then read without STOP
      startCond;
      applyStimulus("rs.waddr", 8'h80, 1'b1, 1'b0);
      checkOutput("rs.rw0", 16'(rw), 16'h0);
      applyStimulus("rs.wdata", 8'h01, 1'b1, 1'b0);
      checkOutput("rs.lastRx", 16'(lastRx), 16'h01);
      startCond;
      applyStimulus("rs.raddr", 8'h81, 1'b1, 1'b1);
      checkOutput("rs.rw1", 16'(rw), 16'h1);
      readByte("rs.b0", 1'b0, 8'h4E);
      stopCond;

      // STOP after four data bits of a write
      rv0 = rxValidCount;
      startCond;
      applyStimulus("sm.addr", 8'h80, 1'b1, 1'b0);
      sendBit(1'b1); sendBit(1'b0); sendBit(1'b1); sendBit(1'b1);
      stopCond;
      waitCyc(2);
      checkOutput("sm.rxCount", 16'(rxValidCount - rv0), 16'h0);
      checkOutput("sm.sdaOe", 16'(sdaOe), 16'h0);
      checkOutput("sm.busy", 16'(busy), 16'h0);

      // Async reset while the slave is ACKing a write byte
      startCond;
      applyStimulus("ar.addr", 8'h80, 1'b1, 1'b0);
      for (int i = 7; i >= 0; i--) sendBit(1'(8'h33 >> i));
      sdaMaster = 1'b1;
      checkOutput("ar.oeBefore", 16'(sdaOe), 16'h1);
      #3 presetn = 1'b0;
      #1;
      checkOutput("ar.oeAsync", 16'(sdaOe), 16'h0);
      checkOutput("ar.busyAsync", 16'(busy), 16'h0);
      waitCyc(2);
      scl = 1'b1; sdaMaster = 1'b1;
      waitCyc(2);
      presetn = 1'b1;
      waitCyc(2);
      rv0 = rxValidCount;
      startCond;
      applyStimulus("ar.addr2", 8'h80, 1'b1, 1'b0);
      applyStimulus("ar.data2", 8'h77, 1'b1, 1'b0);
      checkOutput("ar.rxCount", 16'(rxValidCount - rv0), 16'h1);
      checkOutput("ar.lastRx", 16'(lastRx), 16'h77);
      stopCond;
      checkOutput("ar.busyStop", 16'(busy), 16'h0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
